// File: rtl/memory_responder_pkg.sv
// Shared definitions for the memory responder: bus data width and one-hot FSM state encoding.
package memory_responder_pkg;

    localparam int DATA_W = 16;

    typedef enum logic [4:0] {
        ST_IDLE    = 5'b00001,
        ST_WAIT    = 5'b00010,
        ST_ACCESS  = 5'b00100,
        ST_CAPTURE = 5'b01000,
        ST_DONE    = 5'b10000
    } state_e;

endpackage

// File: rtl/memory_responder.sv
// Responder end of the request/done memory bus: one 16-bit access per request,
// programmable wait states, single-port synchronous word SRAM behind it.
module memory_responder
    import memory_responder_pkg::*;
#(
    parameter int ADDR_W      = 15,
    parameter int WAIT_STATES = 0,
    parameter int WS_W        = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [DATA_W-1:0] memoryAddress,
    input  logic              memoryRequest,
    input  logic              memoryWrite,
    input  logic [DATA_W-1:0] memoryWriteData,
    output logic [DATA_W-1:0] memoryReadData,
    output logic              memoryDone,
    output logic              alignError,
    output logic [ADDR_W-1:0] sram_addr,
    output logic              sram_ce,
    output logic              sram_we,
    output logic [DATA_W-1:0] sram_wdata,
    input  logic [DATA_W-1:0] sram_rdata
);

    localparam logic [WS_W-1:0] WS_LOAD = WS_W'(WAIT_STATES);
    localparam logic [WS_W-1:0] WS_ONE  = WS_W'(1);
    localparam bit              NO_WAIT = (WAIT_STATES == 0);

    state_e            state_q;
    logic [WS_W-1:0]   wait_cnt_q;
    logic              write_q;
    logic [DATA_W-1:0] read_data_q;
    logic              done_q;
    logic              align_err_q;
    logic [ADDR_W-1:0] sram_addr_q;
    logic              sram_ce_q;
    logic              sram_we_q;
    logic [DATA_W-1:0] sram_wdata_q;

    // NOTE: every register here uses <= so all updates see pre-edge values; the
    // async reset clears the SRAM strobes at once, abandoning any access in flight.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            wait_cnt_q   <= '0;
            write_q      <= 1'b0;
            read_data_q  <= '0;
            done_q       <= 1'b0;
            align_err_q  <= 1'b0;
            sram_addr_q  <= '0;
            sram_ce_q    <= 1'b0;
            sram_we_q    <= 1'b0;
            sram_wdata_q <= '0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (memoryRequest) begin
                        sram_addr_q  <= memoryAddress[ADDR_W:1];
                        sram_wdata_q <= memoryWriteData;
                        write_q      <= memoryWrite;
                        wait_cnt_q   <= WS_LOAD;
                        if (memoryAddress[0]) begin
                            align_err_q <= 1'b1;
                        end
                        // Strobes are raised on entry to ACCESS so the SRAM samples at the
                        // end of ACCESS and its read data is stable throughout CAPTURE.
                        if (NO_WAIT) begin
                            state_q   <= ST_ACCESS;
                            sram_ce_q <= 1'b1;
                            sram_we_q <= memoryWrite;
                        end else begin
                            state_q <= ST_WAIT;
                        end
                    end
                end
                ST_WAIT: begin
                    wait_cnt_q <= wait_cnt_q - WS_ONE;
                    if (wait_cnt_q == WS_ONE) begin
                        state_q   <= ST_ACCESS;
                        sram_ce_q <= 1'b1;
                        sram_we_q <= write_q;
                    end
                end
                ST_ACCESS: begin
                    sram_ce_q <= 1'b0;
                    sram_we_q <= 1'b0;
                    state_q   <= ST_CAPTURE;
                end
                ST_CAPTURE: begin
                    if (!write_q) begin
                        read_data_q <= sram_rdata;
                    end
                    done_q  <= 1'b1;
                    state_q <= ST_DONE;
                end
                ST_DONE: begin
                    done_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: begin
                    sram_ce_q <= 1'b0;
                    sram_we_q <= 1'b0;
                    done_q    <= 1'b0;
                    state_q   <= ST_IDLE;
                end
            endcase
        end
    end

    assign memoryReadData = read_data_q;
    assign memoryDone     = done_q;
    assign alignError     = align_err_q;
    assign sram_addr      = sram_addr_q;
    assign sram_ce        = sram_ce_q;
    assign sram_we        = sram_we_q;
    assign sram_wdata     = sram_wdata_q;

endmodule

// File: tb/tb_memory_responder.sv
// Scoreboard bench: three responders (0, 3 and 2 wait states), each with its own SRAM model;
// stimulus pushes expected SRAM accesses and done responses, per-instance monitors pop and compare.
module tb_memory_responder;

    typedef struct {
        logic [14:0] addr;
        logic        we;
        logic [15:0] wdata;
        int          cyc;
    } acc_t;

    typedef struct {
        logic [15:0] data;
        int          cyc;
    } rsp_t;

    logic        clk;
    logic [2:0]  rst_n;
    logic [2:0]  m_req;
    logic [2:0]  m_wr;
    logic [15:0] m_addr  [3];
    logic [15:0] m_wdata [3];
    logic [2:0]  done_v;
    logic [2:0]  align_v;
    logic [2:0]  zero_v;

    acc_t        acc_q [3][$];
    rsp_t        rsp_q [3][$];
    logic [15:0] last_rd [3];

    int cyc;
    int n_pass;
    int n_total;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    function automatic int ws_of(int g);
        return (g == 0) ? 0 : ((g == 1) ? 3 : 2);
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    endtask

    for (genvar g = 0; g < 3; g++) begin : gen_dut
        localparam int WS = (g == 0) ? 0 : ((g == 1) ? 3 : 2);

        logic [15:0] rd_data;
        logic        done;
        logic        align;
        logic [14:0] s_addr;
        logic        s_ce;
        logic        s_we;
        logic [15:0] s_wdata;
        logic [15:0] s_rdata;
        logic [15:0] mem [32768];

        memory_responder #(
            .ADDR_W      (15),
            .WAIT_STATES (WS),
            .WS_W        (4)
        ) u_dut (
            .clk             (clk),
            .reset_n         (rst_n[g]),
            .memoryAddress   (m_addr[g]),
            .memoryRequest   (m_req[g]),
            .memoryWrite     (m_wr[g]),
            .memoryWriteData (m_wdata[g]),
            .memoryReadData  (rd_data),
            .memoryDone      (done),
            .alignError      (align),
            .sram_addr       (s_addr),
            .sram_ce         (s_ce),
            .sram_we         (s_we),
            .sram_wdata      (s_wdata),
            .sram_rdata      (s_rdata)
        );

        initial begin
            if (g == 0) begin
                mem[0] = 16'h1111;
                mem[1] = 16'h5A5A;
                mem[4] = 16'hBEEF;
            end else if (g == 2) begin
                mem[2] = 16'h2222;
            end
        end

        always @(posedge clk) begin
            if (s_ce) begin
                if (s_we) mem[s_addr] <= s_wdata;
                else      s_rdata     <= mem[s_addr];
            end
        end

        assign done_v[g]  = done;
        assign align_v[g] = align;
        assign zero_v[g]  = (rd_data == 16'h0) && !done && !align && (s_addr == 15'h0) &&
                            !s_ce && !s_we && (s_wdata == 16'h0);

        always begin
            acc_t a;
            rsp_t r;
            @(posedge clk);
            #1;
            if (s_ce) begin
                if (acc_q[g].size() == 0) begin
                    check($sformatf("ws%0d unexpected sram access", WS), 32'(s_addr), 32'hFFFF_FFFF);
                end else begin
                    a = acc_q[g].pop_front();
                    check($sformatf("ws%0d sram_addr", WS), 32'(s_addr), 32'(a.addr));
                    check($sformatf("ws%0d sram_we", WS), 32'(s_we), 32'(a.we));
                    check($sformatf("ws%0d sram_ce cycle", WS), cyc, a.cyc);
                    if (a.we) check($sformatf("ws%0d sram_wdata", WS), 32'(s_wdata), 32'(a.wdata));
                end
            end
            if (done) begin
                if (rsp_q[g].size() == 0) begin
                    check($sformatf("ws%0d unexpected done", WS), 32'(done), 32'h0);
                end else begin
                    r = rsp_q[g].pop_front();
                    check($sformatf("ws%0d read data", WS), 32'(rd_data), 32'(r.data));
                    check($sformatf("ws%0d done cycle", WS), cyc, r.cyc);
                end
            end
        end
    end

    // samp: the clk edge at which the responder samples the request.
    task automatic push_req(int g, int samp, logic [15:0] a, logic w, logic [15:0] wd,
                            logic [15:0] exp_rd);
        int   ws = ws_of(g);
        acc_t ac;
        rsp_t rs;
        ac.addr  = a[15:1];
        ac.we    = w;
        ac.wdata = wd;
        ac.cyc   = samp + ws;
        rs.data  = w ? last_rd[g] : exp_rd;
        rs.cyc   = samp + 2 + ws;
        if (!w) last_rd[g] = exp_rd;
        acc_q[g].push_back(ac);
        rsp_q[g].push_back(rs);
    endtask

    task automatic issue(int g, logic [15:0] a, logic w, logic [15:0] wd, logic [15:0] exp_rd);
        @(negedge clk);
        m_addr[g]  = a;
        m_wr[g]    = w;
        m_wdata[g] = wd;
        m_req[g]   = 1'b1;
        push_req(g, cyc + 1, a, w, wd, exp_rd);
        @(negedge clk);
        m_req[g] = 1'b0;
    endtask

    task automatic wait_drain(int g);
        for (int i = 0; i < 60 && (acc_q[g].size() != 0 || rsp_q[g].size() != 0); i++)
            @(negedge clk);
        check($sformatf("inst%0d outstanding after drain", g),
              32'(acc_q[g].size() + rsp_q[g].size()), 32'h0);
        repeat (2) @(negedge clk);
    endtask

    task automatic wait_done_level(int g, string name);
        bit seen = 1'b0;
        for (int i = 0; i < 30 && !seen; i++) begin
            @(negedge clk);
            seen = done_v[g];
        end
        if (!seen) check(name, 32'h0, 32'h1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 3'b000;
        m_req = 3'b000;
        m_wr  = 3'b000;
        for (int g = 0; g < 3; g++) begin
            m_addr[g]  = 16'h0;
            m_wdata[g] = 16'h0;
            last_rd[g] = 16'h0;
        end
        repeat (3) @(negedge clk);
        check("reset outputs zero inst0", 32'(zero_v[0]), 32'h1);
        check("reset outputs zero inst1", 32'(zero_v[1]), 32'h1);
        check("reset outputs zero inst2", 32'(zero_v[2]), 32'h1);
        rst_n = 3'b111;
        repeat (2) @(negedge clk);

        // Zero wait states: read byte 0x0008 -> word 4.
        issue(0, 16'h0008, 1'b0, 16'h0, 16'hBEEF);
        wait_drain(0);

        // Three wait states: write then read back byte 0x0010.
        issue(1, 16'h0010, 1'b1, 16'h1234, 16'h0);
        wait_drain(1);
        issue(1, 16'h0010, 1'b0, 16'h0, 16'h1234);
        wait_drain(1);

        // Back-to-back with request held; address changes in the done cycle.
        @(negedge clk);
        m_addr[0] = 16'h0000;
        m_wr[0]   = 1'b0;
        m_req[0]  = 1'b1;
        push_req(0, cyc + 1, 16'h0000, 1'b0, 16'h0, 16'h1111);
        wait_done_level(0, "b2b first done timeout");
        m_addr[0] = 16'h0002;
        push_req(0, cyc + 2, 16'h0002, 1'b0, 16'h0, 16'h5A5A);
        @(negedge clk);
        wait_done_level(0, "b2b second done timeout");
        m_req[0] = 1'b0;
        wait_drain(0);
        repeat (6) @(negedge clk);

        // Misaligned read: sticky alignError, data from word 1.
        check("alignError before misaligned", 32'(align_v[0]), 32'h0);
        issue(0, 16'h0003, 1'b0, 16'h0, 16'h5A5A);
        wait_drain(0);
        check("alignError after misaligned", 32'(align_v[0]), 32'h1);
        issue(0, 16'h0008, 1'b0, 16'h0, 16'hBEEF);
        wait_drain(0);
        check("alignError sticky", 32'(align_v[0]), 32'h1);

        // Two wait states, request dropped after one cycle.
        issue(2, 16'h0004, 1'b0, 16'h0, 16'h2222);
        wait_drain(2);

        // Reset during WAIT abandons the access.
        @(negedge clk);
        m_addr[1] = 16'h0009;
        m_wr[1]   = 1'b0;
        m_req[1]  = 1'b1;
        @(negedge clk);
        m_req[1] = 1'b0;
        @(negedge clk);
        check("alignError set before reset", 32'(align_v[1]), 32'h1);
        rst_n[1] = 1'b0;
        last_rd[1] = 16'h0;
        #1;
        check("outputs zero during mid-transaction reset", 32'(zero_v[1]), 32'h1);
        repeat (2) @(negedge clk);
        rst_n[1] = 1'b1;
        repeat (10) @(negedge clk);
        check("alignError cleared by reset", 32'(align_v[1]), 32'h0);
        issue(1, 16'h0010, 1'b0, 16'h0, 16'h1234);
        wait_drain(1);

        repeat (5) @(negedge clk);
        for (int g = 0; g < 3; g++)
            check($sformatf("inst%0d queues empty at end", g),
                  32'(acc_q[g].size() + rsp_q[g].size()), 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
